dp_psum_buffer: RTL and testbench

//  Downstream/upstream partial-sum store that sits on the dp_top madd result interface.

---
 rtl/dp_psum_buffer_if.sv | 34 +++
 rtl/dp_psum_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_dp_psum_buffer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_psum_buffer_if.sv
// rtl/dp_psum_buffer_if.sv - madd/psum access and drain stream bundle for dp_psum_buffer
interface dp_psum_buffer_if #(
  parameter int A = 12,
  parameter int W = 468
);
  logic         i_madd_we;
  logic [A-1:0] i_madd_wraddr;
  logic [W-1:0] i_madd_data;
  logic [A-1:0] i_madd_rdaddr;
  logic         i_first_pass;
  logic [W-1:0] o_madd_data;
  logic         i_acc_done;
  logic         o_acc_ready;
  logic         o_overflow;
  logic         o_drain_valid;
  logic         i_drain_ready;
  logic [W-1:0] o_drain_data;
  logic [A-1:0] o_drain_addr;
  logic         o_drain_last;

  modport master (
    output i_madd_we, i_madd_wraddr, i_madd_data, i_madd_rdaddr, i_first_pass,
    output i_acc_done, i_drain_ready,
    input  o_madd_data, o_acc_ready, o_overflow,
    input  o_drain_valid, o_drain_data, o_drain_addr, o_drain_last
  );

  modport slave (
    input  i_madd_we, i_madd_wraddr, i_madd_data, i_madd_rdaddr, i_first_pass,
    input  i_acc_done, i_drain_ready,
    output o_madd_data, o_acc_ready, o_overflow,
    output o_drain_valid, o_drain_data, o_drain_addr, o_drain_last
  );
endinterface

// File: rtl/dp_psum_buffer.sv
// rtl/dp_psum_buffer.sv - double-buffered partial-sum store with credit-based drain stream
module dp_psum_buffer #(
  parameter int COE_WIDTH    = 39,
  parameter int ADDR_WIDTH   = 9,
  parameter int LOG_NUM_BANK = 3,
  parameter int NUM_POLY     = 3,
  parameter int RD_DELAY     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  dp_psum_buffer_if.slave   bus
);
  localparam int A     = ADDR_WIDTH + LOG_NUM_BANK;
  localparam int W     = COE_WIDTH * NUM_POLY * 4;
  localparam int D     = 1 << A;
  localparam int DEPTH = RD_DELAY + 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(2 * DEPTH + 1);
  localparam logic [A-1:0] LAST_ADDR = '1;

  typedef enum logic {ST_FREE, ST_DRAIN} state_t;

  // Both banks live in one array indexed {bank, word address}
  logic [W-1:0]        r_mem [0:2*D-1];

  state_t              r_state;
  logic                r_acc_sel;
  logic                r_acc_ready;
  logic                r_overflow;

  logic [W-1:0]        r_ar_data [RD_DELAY];
  logic [RD_DELAY-1:0] r_ar_zero;

  logic [A-1:0]        r_rd_ptr;
  logic                r_issue_done;

  logic [RD_DELAY-1:0] r_dp_vld;
  logic [A-1:0]        r_dp_addr [RD_DELAY];
  logic [W-1:0]        r_dp_data [RD_DELAY];

  logic [W-1:0]        r_ff_data [DEPTH];
  logic [A-1:0]        r_ff_addr [DEPTH];
  logic [PW-1:0]       r_ff_wp;
  logic [PW-1:0]       r_ff_rp;
  logic [CW-1:0]       r_ff_cnt;

  logic                w_push;
  logic                w_pop;
  logic                w_valid;
  logic                w_last_hs;
  logic                w_issue;
  logic [CW-1:0]       w_inflight;
  logic [A-1:0]        w_head_addr;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Count reads still travelling through the RAM latency pipe
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_DELAY; i++) begin
      w_inflight = w_inflight + CW'(r_dp_vld[i]);
    end
  end

  assign w_push      = r_dp_vld[RD_DELAY-1];
  assign w_valid     = (r_ff_cnt != '0);
  assign w_pop       = w_valid && bus.i_drain_ready;
  assign w_head_addr = r_ff_addr[r_ff_rp];
  assign w_last_hs   = w_pop && (w_head_addr == LAST_ADDR);
  // A slot freed by this cycle's pop may be reused, which keeps one word per cycle
  assign w_issue     = (r_state == ST_DRAIN) && !r_issue_done &&
                       ((r_ff_cnt + w_inflight - CW'(w_pop)) < CW'(DEPTH));

  // RAM ports; NBA ordering gives old data on same-address read/write
  always_ff @(posedge clk) begin
    if (bus.i_madd_we) begin
      r_mem[{r_acc_sel, bus.i_madd_wraddr}] <= bus.i_madd_data;
    end
    r_ar_data[0] <= r_mem[{r_acc_sel, bus.i_madd_rdaddr}];
    r_dp_data[0] <= r_mem[{~r_acc_sel, r_rd_ptr}];
    for (int i = 1; i < RD_DELAY; i++) begin
      r_ar_data[i] <= r_ar_data[i-1];
      r_dp_data[i] <= r_dp_data[i-1];
    end
  end

  // first_pass travels with its read address; reset forces the output to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ar_zero <= '1;
    end else begin
      r_ar_zero[0] <= bus.i_first_pass;
      for (int i = 1; i < RD_DELAY; i++) begin
        r_ar_zero[i] <= r_ar_zero[i-1];
      end
    end
  end

  // Swap FSM for the non-accumulating bank, with sticky overflow on rejected swaps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_FREE;
      r_acc_sel   <= 1'b0;
      r_acc_ready <= 1'b1;
      r_overflow  <= 1'b0;
    end else begin
      if (bus.i_acc_done && !r_acc_ready) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        ST_FREE: begin
          if (bus.i_acc_done) begin
            r_state     <= ST_DRAIN;
            r_acc_sel   <= ~r_acc_sel;
            r_acc_ready <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (w_last_hs) begin
            r_state     <= ST_FREE;
            r_acc_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_FREE;
          r_acc_ready <= 1'b1;
        end
      endcase
    end
  end

  // Drain read pointer: walks 0..D-1 once per drain, rearmed while the bank is free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr     <= '0;
      r_issue_done <= 1'b0;
    end else if (r_state == ST_FREE) begin
      r_rd_ptr     <= '0;
      r_issue_done <= 1'b0;
    end else if (w_issue) begin
      r_rd_ptr <= r_rd_ptr + A'(1);
      if (r_rd_ptr == LAST_ADDR) begin
        r_issue_done <= 1'b1;
      end
    end
  end

  // Valid/address tags matching the drain reads in the RAM latency pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_vld <= '0;
      for (int i = 0; i < RD_DELAY; i++) begin
        r_dp_addr[i] <= '0;
      end
    end else begin
      r_dp_vld[0]  <= w_issue;
      r_dp_addr[0] <= r_rd_ptr;
      for (int i = 1; i < RD_DELAY; i++) begin
        r_dp_vld[i]  <= r_dp_vld[i-1];
        r_dp_addr[i] <= r_dp_addr[i-1];
      end
    end
  end

  // Skid FIFO control and address storage; reset flushes any in-progress drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff_wp  <= '0;
      r_ff_rp  <= '0;
      r_ff_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ff_addr[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_ff_addr[r_ff_wp] <= r_dp_addr[RD_DELAY-1];
        r_ff_wp            <= f_inc(r_ff_wp);
      end
      if (w_pop) begin
        r_ff_rp <= f_inc(r_ff_rp);
      end
      r_ff_cnt <= r_ff_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Skid FIFO data storage
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ff_data[r_ff_wp] <= r_dp_data[RD_DELAY-1];
    end
  end

  assign bus.o_madd_data   = r_ar_zero[RD_DELAY-1] ? '0 : r_ar_data[RD_DELAY-1];
  assign bus.o_acc_ready   = r_acc_ready;
  assign bus.o_overflow    = r_overflow;
  assign bus.o_drain_valid = w_valid;
  assign bus.o_drain_data  = r_ff_data[r_ff_rp];
  assign bus.o_drain_addr  = w_head_addr;
  assign bus.o_drain_last  = w_valid && (w_head_addr == LAST_ADDR);
endmodule

// File: tb/tb_dp_psum_buffer.sv
// tb/tb_dp_psum_buffer.sv - directed self-checking bench for dp_psum_buffer
module tb_dp_psum_buffer;
  localparam int COE_WIDTH    = 39;
  localparam int ADDR_WIDTH   = 5;
  localparam int LOG_NUM_BANK = 2;
  localparam int NUM_POLY     = 3;
  localparam int RD_DELAY     = 2;
  localparam int A = ADDR_WIDTH + LOG_NUM_BANK;
  localparam int W = COE_WIDTH * NUM_POLY * 4;
  localparam int D = 1 << A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dp_psum_buffer_if #(.A(A), .W(W)) pif ();

  dp_psum_buffer #(
    .COE_WIDTH(COE_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .LOG_NUM_BANK(LOG_NUM_BANK),
    .NUM_POLY(NUM_POLY), .RD_DELAY(RD_DELAY)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(pif)
  );

  typedef struct {
    logic [A-1:0] addr;
    logic         fp;
    logic [W-1:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [6];

  function automatic logic [W-1:0] mkw(input int p, input int k);
    logic [W-1:0] v;
    v = '0;
    v[15:0]    = k[15:0];
    v[239:224] = ~k[15:0];
    v[W-1 -: 8] = p[7:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic write_pass(input int p);
    for (int k = 0; k < D; k++) begin
      @(negedge clk);
      pif.i_madd_we     = 1'b1;
      pif.i_madd_wraddr = A'(k);
      pif.i_madd_data   = mkw(p, k);
    end
    @(negedge clk);
    pif.i_madd_we = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [A-1:0] addr, input logic fp,
                          input logic [W-1:0] exp);
    @(negedge clk);
    pif.i_madd_rdaddr = addr;
    pif.i_first_pass  = fp;
    repeat (RD_DELAY) @(negedge clk);
    chk(name, pif.o_madd_data, exp);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    chk1("acc_ready_before_swap", pif.o_acc_ready, 1'b1);
    pif.i_acc_done = 1'b1;
  endtask

  // Consumes n_words drain handshakes; optional acc_done on handshake done_at,
  // optional re-request on the cycle right after the final handshake.
  task automatic drain_bank(input int pass, input int stall_pct, input int done_at,
                            input int n_words, input bit full_rate, input bit redo);
    int exp_k = 0;
    int cyc = 0;
    int first = -1;
    bit held = 1'b0;
    logic [W-1:0] hd = '0;
    logic [A-1:0] ha = '0;
    while (exp_k < n_words && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      pif.i_acc_done = 1'b0;
      if (cyc == 1) chk1("acc_ready_low_after_swap", pif.o_acc_ready, 1'b0);
      if (held) begin
        chk1("stall_valid_held", pif.o_drain_valid, 1'b1);
        chk("stall_data_held", pif.o_drain_data, hd);
        chk("stall_addr_held", W'(pif.o_drain_addr), W'(ha));
      end
      if (first >= 0 && full_rate) chk1("no_gap_full_rate", pif.o_drain_valid, 1'b1);
      pif.i_drain_ready = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
      if (pif.o_drain_valid) begin
        if (first < 0) begin
          first = cyc;
          chk1("first_valid_latency", (cyc >= RD_DELAY + 1), 1'b1);
        end
        if (pif.i_drain_ready) begin
          chk("drain_addr", W'(pif.o_drain_addr), W'(exp_k));
          chk("drain_data", pif.o_drain_data, mkw(pass, exp_k));
          chk1("drain_last", pif.o_drain_last, (exp_k == D - 1));
          if (exp_k == done_at) begin
            pif.i_acc_done = 1'b1;
            chk1("acc_ready_low_in_drain", pif.o_acc_ready, 1'b0);
          end
          exp_k++;
        end
      end
      held = pif.o_drain_valid && !pif.i_drain_ready;
      hd = pif.o_drain_data;
      ha = pif.o_drain_addr;
    end
    if (exp_k < n_words) chk("drain_timeout_words", W'(exp_k), W'(n_words));
    @(negedge clk);
    pif.i_drain_ready = 1'b0;
    pif.i_acc_done    = 1'b0;
    if (n_words == D) chk1("acc_ready_after_last", pif.o_acc_ready, 1'b1);
    if (redo) pif.i_acc_done = 1'b1;
  endtask

  initial begin
    pif.i_madd_we     = 1'b0;
    pif.i_madd_wraddr = '0;
    pif.i_madd_data   = '0;
    pif.i_madd_rdaddr = '0;
    pif.i_first_pass  = 1'b0;
    pif.i_acc_done    = 1'b0;
    pif.i_drain_ready = 1'b0;

    tbl[0] = '{addr: A'(5),     fp: 1'b1, exp: {W{1'b0}}};
    tbl[1] = '{addr: A'(5),     fp: 1'b0, exp: mkw(1, 5)};
    tbl[2] = '{addr: A'(0),     fp: 1'b0, exp: mkw(1, 0)};
    tbl[3] = '{addr: A'(D - 1), fp: 1'b0, exp: mkw(1, D - 1)};
    tbl[4] = '{addr: A'(D - 1), fp: 1'b1, exp: {W{1'b0}}};
    tbl[5] = '{addr: A'(64),    fp: 1'b0, exp: mkw(1, 64)};

    repeat (3) @(negedge clk);
    chk1("rst_acc_ready", pif.o_acc_ready, 1'b1);
    chk1("rst_overflow", pif.o_overflow, 1'b0);
    chk1("rst_drain_valid", pif.o_drain_valid, 1'b0);
    chk1("rst_drain_last", pif.o_drain_last, 1'b0);
    chk("rst_drain_addr", W'(pif.o_drain_addr), W'(0));
    chk("rst_madd_data", pif.o_madd_data, '0);
    rst_n = 1'b1;

    // Fill bank0, then psum reads from the table
    write_pass(1);
    for (int i = 0; i < 6; i++) begin
      rd_check("psum_read", tbl[i].addr, tbl[i].fp, tbl[i].exp);
    end

    // first_pass must stay aligned with its own address on back-to-back reads
    @(negedge clk);
    pif.i_madd_rdaddr = A'(5);
    pif.i_first_pass  = 1'b1;
    @(negedge clk);
    pif.i_madd_rdaddr = A'(6);
    pif.i_first_pass  = 1'b0;
    @(negedge clk);
    chk("pipe_fp_zero", pif.o_madd_data, '0);
    @(negedge clk);
    chk("pipe_fp_data", pif.o_madd_data, mkw(1, 6));

    // Same-cycle read and write of one address returns the old word
    @(negedge clk);
    pif.i_madd_we     = 1'b1;
    pif.i_madd_wraddr = A'(9);
    pif.i_madd_data   = mkw(7, 9);
    pif.i_madd_rdaddr = A'(9);
    pif.i_first_pass  = 1'b0;
    @(negedge clk);
    pif.i_madd_we = 1'b0;
    @(negedge clk);
    chk("read_first_old", pif.o_madd_data, mkw(1, 9));
    rd_check("read_after_write", A'(9), 1'b0, mkw(7, 9));
    @(negedge clk);
    pif.i_madd_we     = 1'b1;
    pif.i_madd_wraddr = A'(9);
    pif.i_madd_data   = mkw(1, 9);
    @(negedge clk);
    pif.i_madd_we = 1'b0;

    // Full-rate drain of bank0
    pulse_done();
    drain_bank(1, 0, -1, D, 1'b1, 1'b0);
    chk1("no_overflow_yet", pif.o_overflow, 1'b0);

    // Drain under random back-pressure
    write_pass(2);
    pulse_done();
    drain_bank(2, 30, -1, D, 1'b0, 1'b0);

    // acc_done mid-drain is rejected and flags overflow
    write_pass(3);
    pulse_done();
    drain_bank(3, 30, 40, D, 1'b0, 1'b0);
    chk1("overflow_sticky", pif.o_overflow, 1'b1);

    // acc_done on the final handshake is rejected, the next cycle it is accepted
    write_pass(4);
    pulse_done();
    drain_bank(4, 0, D - 1, D, 1'b1, 1'b1);
    drain_bank(3, 0, -1, 20, 1'b1, 1'b0);

    // Reset in the middle of that drain
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("midrst_drain_valid", pif.o_drain_valid, 1'b0);
    chk1("midrst_acc_ready", pif.o_acc_ready, 1'b1);
    chk1("midrst_overflow", pif.o_overflow, 1'b0);
    chk1("midrst_drain_last", pif.o_drain_last, 1'b0);
    chk("midrst_drain_addr", W'(pif.o_drain_addr), W'(0));
    chk("midrst_madd_data", pif.o_madd_data, '0);
    @(negedge clk);
    rst_n = 1'b1;

    write_pass(6);
    pulse_done();
    drain_bank(6, 0, -1, D, 1'b1, 1'b0);
    chk1("final_overflow", pif.o_overflow, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
